// File: rtl/sram_rmw_adapter.sv
// -----------------------------------------------------------------------------
// sram_rmw_adapter
//
// Purpose:
//   Bridges a valid/ready request/response interface onto the raw port of a
//   single-port tc_sram. The SRAM macros behind tc_sram ignore byte enables,
//   so every partial-byte write becomes a read-modify-write: read the word,
//   merge the enabled lanes, write the full word back. The SRAM always sees
//   full-word writes.
//
//   Full-word writes and reads issue to the SRAM in the cycle they are
//   accepted. A write with no byte enabled is accepted and dropped. Partial
//   writes occupy the block for Latency+2 cycles. Everything completes in
//   acceptance order, so a read accepted after a partial write sees the
//   merged word.
//
// Handshake:
//   A transfer happens on a rising clk_i edge where valid and ready are both
//   high. The source holds valid and its payload stable until that edge.
//   rsp_valid_o and rsp_rdata_o stay stable until rsp_ready_i is seen high
//   (reset is the only exception). req_ready_o depends only on the state,
//   never on req_valid_i.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake
//   req_we_i              1 = write, 0 = read
//   req_addr_i            word address (forwarded unchanged, no range check)
//   req_wdata_i/be_i      write data and byte enables
//   rsp_valid_o/ready_i   read response handshake (reads only)
//   rsp_rdata_o           read data
//   sram_*                raw tc_sram port; sram_be_o is tied all-ones,
//                         sram_rdata_i is valid Latency cycles after a read
//   perf_rmw_cnt_o        saturating count of RMW write-backs
//                         (present only with SRAM_RMW_PERF_CNT_EN defined)
//   dbg_state_o           current FSM state (IDLE=0, RD_WAIT=1, RSP=2,
//                         RMW_WAIT=3, RMW_WR=4)
//
// Configuration macro:
//   SRAM_RMW_PERF_CNT_EN  adds the perf_rmw_cnt_o port and its counter.
//
// Latency must be >= 1.
// -----------------------------------------------------------------------------
module sram_rmw_adapter #(
   parameter int unsigned NumWords  = 256,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned ByteWidth = 8,
   parameter int unsigned Latency   = 1,
   parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [DataWidth-1:0] req_wdata_i,
   input  logic [BeWidth-1:0]   req_be_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DataWidth-1:0] rsp_rdata_o,
   output logic                 sram_req_o,
   output logic                 sram_we_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   output logic [BeWidth-1:0]   sram_be_o,
   input  logic [DataWidth-1:0] sram_rdata_i,
`ifdef SRAM_RMW_PERF_CNT_EN
   output logic [15:0]          perf_rmw_cnt_o,
`endif
   output logic [2:0]           dbg_state_o
);

   // Wide enough to hold the value Latency.
   localparam int unsigned CntWidth = (Latency > 1) ? $clog2(Latency + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_WAIT  = 3'd1,
      S_RSP      = 3'd2,
      S_RMW_WAIT = 3'd3,
      S_RMW_WR   = 3'd4
   } state_e;

   state_e               r_state;
   state_e               w_state_next;

   logic [CntWidth-1:0]  r_cnt;
   logic [AddrWidth-1:0] r_addr;
   logic [DataWidth-1:0] r_wdata;
   logic [BeWidth-1:0]   r_be;
   logic [DataWidth-1:0] r_merge;
   logic [DataWidth-1:0] r_rdata;

   logic                 w_accept;
   logic                 w_be_full;
   logic                 w_be_none;
   logic                 w_start_rd;
   logic                 w_start_rmw;
   logic                 w_cnt_done;
   logic [DataWidth-1:0] w_merged;

   // Accept is derived from the state directly so it does not loop through
   // the output process that also drives req_ready_o.
   assign w_accept    = req_valid_i & (r_state == S_IDLE);
   assign w_be_full   = &req_be_i;
   assign w_be_none   = ~|req_be_i;
   assign w_start_rd  = w_accept & ~req_we_i;
   assign w_start_rmw = w_accept & req_we_i & ~w_be_full & ~w_be_none;

   // The counter is loaded with Latency on accept; the SRAM data is valid in
   // the cycle the counter reads 1.
   assign w_cnt_done  = (r_cnt == CntWidth'(1));

   // Per-lane merge. Bit i belongs to lane i/ByteWidth, so when DataWidth is
   // not a multiple of ByteWidth the last lane simply covers the leftover
   // high bits.
   for (genvar gi = 0; gi < DataWidth; gi++) begin : g_merge
      assign w_merged[gi] = r_be[gi / ByteWidth] ? r_wdata[gi] : sram_rdata_i[gi];
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_rd) begin
               w_state_next = S_RD_WAIT;
            end else if (w_start_rmw) begin
               w_state_next = S_RMW_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (w_cnt_done) begin
               w_state_next = S_RSP;
            end
         end
         S_RSP: begin
            if (rsp_ready_i) begin
               w_state_next = S_IDLE;
            end
         end
         S_RMW_WAIT: begin
            if (w_cnt_done) begin
               w_state_next = S_RMW_WR;
            end
         end
         S_RMW_WR: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // In IDLE the SRAM port follows the incoming request combinationally so
   // reads and full writes reach the SRAM in their accept cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      req_ready_o  = 1'b0;
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = req_addr_i;
      sram_wdata_o = req_wdata_i;
      case (r_state)
         S_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               if (!req_we_i) begin
                  sram_req_o = 1'b1;
               end else if (w_be_full) begin
                  sram_req_o = 1'b1;
                  sram_we_o  = 1'b1;
               end else if (!w_be_none) begin
                  // Partial write: fetch the old word first.
                  sram_req_o = 1'b1;
               end
            end
         end
         S_RMW_WR: begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = r_addr;
            sram_wdata_o = r_merge;
         end
         default: begin
         end
      endcase
   end

   assign rsp_valid_o = (r_state == S_RSP);
   assign rsp_rdata_o = r_rdata;
   assign sram_be_o   = '1;
   assign dbg_state_o = r_state;

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_merge <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start_rd || w_start_rmw) begin
                  r_cnt   <= CntWidth'(Latency);
                  r_addr  <= req_addr_i;
                  r_wdata <= req_wdata_i;
                  r_be    <= req_be_i;
               end
            end
            S_RD_WAIT: begin
               if (w_cnt_done) begin
                  r_rdata <= sram_rdata_i;
               end else begin
                  r_cnt <= r_cnt - CntWidth'(1);
               end
            end
            S_RMW_WAIT: begin
               if (w_cnt_done) begin
                  r_merge <= w_merged;
               end else begin
                  r_cnt <= r_cnt - CntWidth'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef SRAM_RMW_PERF_CNT_EN
   // ---------------------------------------------------------------------------
   // Saturating count of RMW write-backs.
   // ---------------------------------------------------------------------------
   logic [15:0] r_perf_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_perf_cnt <= '0;
      end else if ((r_state == S_RMW_WR) && (r_perf_cnt != 16'hFFFF)) begin
         r_perf_cnt <= r_perf_cnt + 16'd1;
      end
   end

   assign perf_rmw_cnt_o = r_perf_cnt;
`endif

endmodule

// File: tb/tb_sram_rmw_adapter.sv
module tb_sram_rmw_adapter;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Index 0: Latency=1 instance, index 1: Latency=3 instance.
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0]       req_we = '0;
  logic [1:0][7:0]  req_addr = '0;
  logic [1:0][31:0] req_wdata = '0;
  logic [1:0][3:0]  req_be = '0;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready = 2'b11;
  logic [1:0][31:0] rsp_rdata;
  logic [1:0]       sram_req;
  logic [1:0]       sram_we;
  logic [1:0][7:0]  sram_addr;
  logic [1:0][31:0] sram_wdata;
  logic [1:0][3:0]  sram_be;
  logic [1:0][2:0]  dbg_state;
`ifdef SRAM_RMW_PERF_CNT_EN
  logic [1:0][15:0] perf;
  int exp_perf [2] = '{0, 0};
`endif

  // ---------------------------------------------------------------------------
  // SRAM models (full-word, byte enables ignored like the real macro)
  // ---------------------------------------------------------------------------
  logic [31:0] mem  [2][256];
  logic [31:0] pipe [2][3];
  int          wr_cnt [2] = '{0, 0};
  bit          mem_loaded = 1'b0;

  function automatic logic [31:0] init_word(int s, int i);
    if (s == 0 && i == 5) return 32'h1122_3344;
    return (32'(i) * 32'h9E37_79B1) ^ ((s == 0) ? 32'h0000_A5A5 : 32'h5A5A_0000);
  endfunction

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < 256; i++) mem[s][i] <= init_word(s, i);
      mem_loaded <= 1'b1;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (sram_req[s] && sram_we[s]) begin
          mem[s][sram_addr[s]] <= sram_wdata[s];
          wr_cnt[s] <= wr_cnt[s] + 1;
        end
        if (sram_req[s] && !sram_we[s]) pipe[s][0] <= mem[s][sram_addr[s]];
        pipe[s][1] <= pipe[s][0];
        pipe[s][2] <= pipe[s][1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  sram_rmw_adapter #(.Latency(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_be_i(req_be[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
    .sram_req_o(sram_req[0]), .sram_we_o(sram_we[0]), .sram_addr_o(sram_addr[0]),
    .sram_wdata_o(sram_wdata[0]), .sram_be_o(sram_be[0]), .sram_rdata_i(pipe[0][0]),
`ifdef SRAM_RMW_PERF_CNT_EN
    .perf_rmw_cnt_o(perf[0]),
`endif
    .dbg_state_o(dbg_state[0])
  );

  sram_rmw_adapter #(.Latency(3)) dut_l3 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_be_i(req_be[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
    .sram_req_o(sram_req[1]), .sram_we_o(sram_we[1]), .sram_addr_o(sram_addr[1]),
    .sram_wdata_o(sram_wdata[1]), .sram_be_o(sram_be[1]), .sram_rdata_i(pipe[1][2]),
`ifdef SRAM_RMW_PERF_CNT_EN
    .perf_rmw_cnt_o(perf[1]),
`endif
    .dbg_state_o(dbg_state[1])
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] ref_mem [2][256];
  int bp_mode = 0;  // 0 always ready, 1 random, 2 hold ready low for 5 cycles
  int last_acc_cyc = 0;
  int last_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, want %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: issue one request, check the SRAM port in the accept cycle and,
  // for a partial write, the write-back and the busy window.
  // Called at (or just after) a falling edge; returns just after a falling edge.
  // ---------------------------------------------------------------------------
  task automatic send(input int s, input logic we, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    int n;
    int nwr;
    int lat;
    logic [31:0] merged;
    lat = (s == 0) ? 1 : 3;
    req_we[s] = we; req_addr[s] = a; req_wdata[s] = d; req_be[s] = be; req_valid[s] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[s] && n < 100) begin @(negedge clk); #1; n++; end
    last_wait = n;
    if (!req_ready[s]) begin
      chk1("req_accept_timeout", req_ready[s], 1'b1);
      req_valid[s] = 1'b0;
      return;
    end
    // Accept happens on the coming rising edge.
    last_acc_cyc = cyc;
    merged = merge(ref_mem[s][a], d, be);
    chk("acc_sram_be", 32'(sram_be[s]), 32'h0000_000F);
    if (!we) begin
      if (s == 0) exp_q0.push_back(ref_mem[s][a]); else exp_q1.push_back(ref_mem[s][a]);
      chk1("rd_sram_req", sram_req[s], 1'b1);
      chk1("rd_sram_we", sram_we[s], 1'b0);
      chk("rd_sram_addr", 32'(sram_addr[s]), 32'(a));
    end else if (be == 4'hF) begin
      ref_mem[s][a] = d;
      chk1("fw_sram_req", sram_req[s], 1'b1);
      chk1("fw_sram_we", sram_we[s], 1'b1);
      chk("fw_sram_addr", 32'(sram_addr[s]), 32'(a));
      chk("fw_sram_wdata", sram_wdata[s], d);
    end else if (be == 4'h0) begin
      chk1("be0_sram_req", sram_req[s], 1'b0);
    end else begin
      ref_mem[s][a] = merged;
      chk1("rmw_rd_req", sram_req[s], 1'b1);
      chk1("rmw_rd_we", sram_we[s], 1'b0);
      chk("rmw_rd_addr", 32'(sram_addr[s]), 32'(a));
    end
    @(negedge clk);
    req_valid[s] = 1'b0;
    if (we && be != 4'hF && be != 4'h0) begin
      #1;
      n = 1; nwr = 0;
      while (!req_ready[s] && n < 100) begin
        if (sram_req[s] && sram_we[s]) begin
          nwr++;
          chk("rmw_wr_addr", 32'(sram_addr[s]), 32'(a));
          chk("rmw_wr_data", sram_wdata[s], merged);
        end
        @(negedge clk); #1; n++;
      end
      chk("rmw_occupancy", 32'(n), 32'(lat + 2));
      chk("rmw_write_count", 32'(nwr), 32'd1);
`ifdef SRAM_RMW_PERF_CNT_EN
      if (exp_perf[s] < 65535) exp_perf[s]++;
`endif
    end
  endtask

  // Cycles from accept to rsp_valid; call right after send() of a read.
  task automatic check_rd_latency(input int s, input string name);
    int k;
    #1;
    k = 1;
    while (!rsp_valid[s] && k < 50) begin @(negedge clk); #1; k++; end
    chk(name, 32'(k), 32'((s == 0) ? 2 : 4));
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops the expected queue on every response handshake, checks
  // response stability under back-pressure and that requests are blocked.
  // ---------------------------------------------------------------------------
  bit          pend [2] = '{0, 0};
  logic [31:0] pdata [2];
  int          age [2] = '{0, 0};
  bit          after_hs [2] = '{0, 0};

  task automatic mon(input int s);
    logic [31:0] e;
    int sz;
    if (rst) begin
      pend[s] = 0; age[s] = 0; after_hs[s] = 0; rsp_ready[s] = 1'b1;
      return;
    end
    if (after_hs[s]) begin
      chk1("post_rsp_req_ready", req_ready[s], 1'b1);
      chk1("post_rsp_valid_low", rsp_valid[s], 1'b0);
      after_hs[s] = 0;
    end
    if (pend[s]) begin
      chk1("bp_valid_held", rsp_valid[s], 1'b1);
      chk("bp_rdata_stable", rsp_rdata[s], pdata[s]);
    end
    age[s] = rsp_valid[s] ? age[s] + 1 : 0;
    if (s == 1 || bp_mode == 0) rsp_ready[s] = 1'b1;
    else if (bp_mode == 1)      rsp_ready[s] = ($urandom_range(0, 3) != 0);
    else                        rsp_ready[s] = (age[s] >= 6);
    pend[s] = 0;
    if (rsp_valid[s]) begin
      chk1("rsp_blocks_req", req_ready[s], 1'b0);
      if (rsp_ready[s]) begin
        sz = (s == 0) ? exp_q0.size() : exp_q1.size();
        if (sz == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rsp_unexpected: inst %0d got 0x%08h, want no response", s, rsp_rdata[s]);
        end else begin
          e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk((s == 0) ? "rsp_rdata_l1" : "rsp_rdata_l3", rsp_rdata[s], e);
        end
        after_hs[s] = 1;
      end else begin
        pend[s] = 1;
        pdata[s] = rsp_rdata[s];
      end
    end
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) mon(s);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t0;
    int n;
    int c;
    int waits;
    logic [7:0] a;
    logic [3:0] be;
    int wc;

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) ref_mem[s][i] = init_word(s, i);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk1("reset_req_ready", req_ready[s], 1'b1);
      chk1("reset_rsp_valid", rsp_valid[s], 1'b0);
      chk("reset_rsp_rdata", rsp_rdata[s], 32'h0);
      chk1("reset_sram_req", sram_req[s], 1'b0);
      chk("reset_state_idle", 32'(dbg_state[s]), 32'h0);
`ifdef SRAM_RMW_PERF_CNT_EN
      chk("reset_perf", 32'(perf[s]), 32'h0);
`endif
    end
    rst = 1'b0;
    @(negedge clk);

    // Full write then read
    send(0, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF);
    send(0, 1'b0, 8'h10, 32'h0, 4'h0);
    check_rd_latency(0, "rd_latency_l1");
    @(negedge clk);

    // Partial write merge then read back
    send(0, 1'b1, 8'h05, 32'hAABB_CCDD, 4'b0101);
    chk("merge_expected_word", ref_mem[0][5], 32'h11BB_33DD);
    send(0, 1'b0, 8'h05, 32'h0, 4'h0);
`ifdef SRAM_RMW_PERF_CNT_EN
    chk("perf_after_rmw", 32'(perf[0]), 32'd1);
`endif
    repeat (3) @(negedge clk);

    // Back-pressure: response held for 5 cycles, accepted on the 6th
    bp_mode = 2;
    send(0, 1'b0, 8'h20, 32'h0, 4'h0);
    #1;
    n = 0;
    while (!rsp_valid[0] && n < 50) begin @(negedge clk); #1; n++; end
    c = 0;
    while (rsp_valid[0] && c < 50) begin c++; @(negedge clk); #1; end
    chk("bp_valid_cycles", 32'(c), 32'd6);
    chk1("bp_ready_after", req_ready[0], 1'b1);
    bp_mode = 0;
    @(negedge clk);

    // Throughput: four back-to-back full writes
    waits = 0;
    send(0, 1'b1, 8'h00, $urandom, 4'hF);
    t0 = last_acc_cyc;
    waits += last_wait;
    for (int i = 1; i < 4; i++) begin
      send(0, 1'b1, 8'(i), $urandom, 4'hF);
      waits += last_wait;
    end
    chk("tput_span", 32'(last_acc_cyc - t0), 32'd3);
    chk("tput_waits", 32'(waits), 32'd0);
    for (int i = 0; i < 4; i++) send(0, 1'b0, 8'(i), 32'h0, 4'h0);
    repeat (4) @(negedge clk);

    // Reset in the RMW_WAIT cycle: the partial write is dropped
    wc = wr_cnt[0];
    req_we[0] = 1'b1; req_addr[0] = 8'h09; req_wdata[0] = 32'h0BAD_F00D;
    req_be[0] = 4'b0011; req_valid[0] = 1'b1;
    #1;
    chk1("rstmid_accept_ready", req_ready[0], 1'b1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    chk1("rstmid_busy", req_ready[0], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("rstmid_req_ready", req_ready[0], 1'b1);
    chk1("rstmid_rsp_valid", rsp_valid[0], 1'b0);
    chk("rstmid_rsp_rdata", rsp_rdata[0], 32'h0);
`ifdef SRAM_RMW_PERF_CNT_EN
    exp_perf[0] = 0; exp_perf[1] = 0;
    chk("rstmid_perf", 32'(perf[0]), 32'h0);
`endif
    repeat (4) @(negedge clk);
    chk("rstmid_no_write", 32'(wr_cnt[0]), 32'(wc));
    chk("rstmid_word_unchanged", mem[0][9], ref_mem[0][9]);
    send(0, 1'b0, 8'h09, 32'h0, 4'h0);
    repeat (3) @(negedge clk);

    // Latency=3 instance: be=0 write, partial write, reads
    wc = wr_cnt[1];
    send(1, 1'b1, 8'h07, 32'hCAFE_F00D, 4'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("be0_no_sram_activity", sram_req[1], 1'b0);
      @(negedge clk);
    end
    chk("be0_no_write", 32'(wr_cnt[1]), 32'(wc));
    send(1, 1'b0, 8'h07, 32'h0, 4'h0);
    check_rd_latency(1, "rd_latency_l3");
    @(negedge clk);
    send(1, 1'b1, 8'h08, 32'h1234_5678, 4'b1001);
    send(1, 1'b0, 8'h08, 32'h0, 4'h0);
    repeat (8) @(negedge clk);

    // Randomised traffic with random back-pressure
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: be = 4'hF;
        1: be = 4'h0;
        default: be = 4'($urandom_range(0, 15));
      endcase
      send(0, 1'($urandom_range(0, 1)), a, $urandom, be);
    end
    n = 0;
    while (exp_q0.size() != 0 && n < 300) begin @(negedge clk); n++; end
    bp_mode = 0;
    repeat (3) @(negedge clk);

    chk("final_q0_empty", 32'(exp_q0.size()), 32'd0);
    chk("final_q1_empty", 32'(exp_q1.size()), 32'd0);
`ifdef SRAM_RMW_PERF_CNT_EN
    chk("final_perf_l1", 32'(perf[0]), 32'(exp_perf[0]));
    chk("final_perf_l3", 32'(perf[1]), 32'(exp_perf[1]));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit
  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
